// File: rtl/tensor_core_scheduler_if.sv
// Requester and result-sink handshake bundle of the tensor core scheduler.
// master = requester/sink side, slave = scheduler side.
interface tensor_core_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    in_valid;
    logic [NUM_REQ*16-1:0] in_a;
    logic [NUM_REQ*16-1:0] in_b;
    logic                  in_ready;
    logic [31:0]           out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [2:0]            out_id;

    modport master (
        output req, in_valid, in_a, in_b, out_ready,
        input  grant, in_ready, out_data, out_valid, out_id
    );

    modport slave (
        input  req, in_valid, in_a, in_b, out_ready,
        output grant, in_ready, out_data, out_valid, out_id
    );
endinterface

// File: rtl/tensor_core_scheduler.sv
// Round-robin scheduler sharing one bit-serial 16x16 tensor core between NUM_REQ requesters.
// Optional word-wait watchdog enabled by defining TC_SCHED_TIMEOUT_EN (adds timeout_err port).
module tensor_core_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned COMPUTE_CYCLES = 8,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    tensor_core_scheduler_if.slave  bus,
    output logic                    core_rst_n,
    output logic                    core_serial_a,
    output logic                    core_serial_b,
    input  logic                    core_serial_out,
    output logic                    busy
`ifdef TC_SCHED_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);
    typedef enum logic [3:0] {
        S_IDLE, S_CRST, S_LOAD_WAIT, S_LOAD_SHIFT, S_COMPUTE,
        S_UNLOAD, S_OUT_HOLD, S_ABORT, S_RELEASE
    } state_t;

    localparam int unsigned CW = $clog2(COMPUTE_CYCLES + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || COMPUTE_CYCLES == 0 || TIMEOUT == 0) begin : g_bad_cfg
        $error("tensor_core_scheduler: unsupported parameter set");
    end

    state_t             state_q, state_d;
    logic [2:0]         owner, ptr, pick, pick_hi, pick_lo;
    logic               found_hi, found_lo;
    logic [NUM_REQ-1:0] gnt_q, pick_oh;
    logic [15:0]        sh_a, sh_b, a_sel, b_sel;
    logic               v_sel, accept, wd_expire;
    logic [4:0]         bit_cnt, word_cnt, res_cnt;
    logic [CW-1:0]      cmp_cnt;
    logic [30:0]        res_sh;

    // First requester at or after the pointer, else the lowest one (wrap).
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (bus.req[j] && !found_lo) begin
                pick_lo  = 3'(j);
                found_lo = 1'b1;
            end
            if (bus.req[j] && !found_hi && 3'(j) >= ptr) begin
                pick_hi  = 3'(j);
                found_hi = 1'b1;
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            pick_oh[j] = (3'(j) == pick);
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        v_sel = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (3'(j) == owner) begin
                a_sel = bus.in_a[16*j +: 16];
                b_sel = bus.in_b[16*j +: 16];
                v_sel = bus.in_valid[j];
            end
        end
    end

    assign accept = (state_q == S_LOAD_WAIT) && v_sel;

`ifdef TC_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;
    logic          waiting;

    assign waiting   = ((state_q == S_LOAD_WAIT) && !accept) ||
                       ((state_q == S_OUT_HOLD) && !bus.out_ready);
    assign wd_expire = waiting && (wd_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || !waiting) wd_cnt <= '0;
        else                 wd_cnt <= wd_cnt + TW'(1);
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (|bus.req) state_d = S_CRST;
            S_CRST:       state_d = S_LOAD_WAIT;
            S_LOAD_WAIT:  if (accept) state_d = S_LOAD_SHIFT;
                          else if (wd_expire) state_d = S_ABORT;
            S_LOAD_SHIFT: if (bit_cnt == 5'd15)
                              state_d = (word_cnt == 5'd16) ? S_COMPUTE : S_LOAD_WAIT;
            S_COMPUTE:    if (cmp_cnt == CW'(COMPUTE_CYCLES - 1)) state_d = S_UNLOAD;
            S_UNLOAD:     if (bit_cnt == 5'd31) state_d = S_OUT_HOLD;
            S_OUT_HOLD:   if (bus.out_ready)
                              state_d = (res_cnt == 5'd15) ? S_RELEASE : S_UNLOAD;
                          else if (wd_expire) state_d = S_ABORT;
            S_ABORT:      state_d = S_RELEASE;
            S_RELEASE:    state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_LOAD_WAIT);
        bus.out_valid = (state_q == S_OUT_HOLD);
        bus.grant     = (state_q inside {S_IDLE, S_RELEASE}) ? '0 : gnt_q;
        busy          = (state_q != S_IDLE);
        core_serial_a = (state_q == S_LOAD_SHIFT) && sh_a[0];
        core_serial_b = (state_q == S_LOAD_SHIFT) && sh_b[0];
`ifdef TC_SCHED_TIMEOUT_EN
        timeout_err   = (state_q == S_ABORT);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_rst_n   <= 1'b0;
            owner        <= '0;
            ptr          <= '0;
            gnt_q        <= '0;
            sh_a         <= '0;
            sh_b         <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            res_cnt      <= '0;
            cmp_cnt      <= '0;
            res_sh       <= '0;
            bus.out_data <= '0;
            bus.out_id   <= '0;
        end else begin
            core_rst_n <= !(state_d inside {S_CRST, S_ABORT});
            case (state_q)
                S_IDLE: if (|bus.req) begin
                    owner <= pick;
                    gnt_q <= pick_oh;
                end
                S_CRST: begin
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                    res_cnt  <= '0;
                end
                S_LOAD_WAIT: if (accept) begin
                    sh_a     <= a_sel;
                    sh_b     <= b_sel;
                    word_cnt <= word_cnt + 5'd1;
                    bit_cnt  <= '0;
                end
                S_LOAD_SHIFT: begin
                    sh_a    <= sh_a >> 1;
                    sh_b    <= sh_b >> 1;
                    bit_cnt <= (bit_cnt == 5'd15) ? 5'd0 : bit_cnt + 5'd1;
                    cmp_cnt <= '0;
                end
                S_COMPUTE: begin
                    cmp_cnt <= cmp_cnt + CW'(1);
                    bit_cnt <= '0;
                end
                // bit_cnt wraps 31 -> 0 so the next UNLOAD starts clean.
                S_UNLOAD: begin
                    res_sh  <= {core_serial_out, res_sh[30:1]};
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        bus.out_data <= {core_serial_out, res_sh};
                        bus.out_id   <= owner;
                    end
                end
                S_OUT_HOLD: if (bus.out_ready) res_cnt <= res_cnt + 5'd1;
                S_RELEASE: begin
                    ptr   <= (owner == 3'(NUM_REQ - 1)) ? 3'd0 : owner + 3'd1;
                    gnt_q <= '0;
                end
                default: ;
            endcase
            if (state_d == S_ABORT) bus.out_id <= owner;
        end
    end
endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Directed self-checking bench for tensor_core_scheduler.
// Define TC_SCHED_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=16).
module tb_tensor_core_scheduler;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned BUSY_LEN = 1 + 272 + 8 + 16*33 + 1;

    logic clk = 1'b0;
    logic rst;
    logic core_rst_n, core_serial_a, core_serial_b, core_serial_out, busy;
`ifdef TC_SCHED_TIMEOUT_EN
    logic timeout_err;
`endif
    int checks = 0;
    int errors = 0;

    tensor_core_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    tensor_core_scheduler #(
        .NUM_REQ(NUM_REQ),
        .COMPUTE_CYCLES(8),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .core_rst_n(core_rst_n),
        .core_serial_a(core_serial_a),
        .core_serial_b(core_serial_b),
        .core_serial_out(core_serial_out),
        .busy(busy)
`ifdef TC_SCHED_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int unsigned r);
        return {16'hC0DE ^ 16'(r), 16'(r * 257 + 3)};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        bus.req = '0; bus.in_valid = '0; bus.in_a = '0; bus.in_b = '0;
        bus.out_ready = 1'b0; core_serial_out = 1'b0;
        tick; tick;
        checks++; if (bus.grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0", bus.grant); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
        checks++; if (bus.out_id !== 3'd0) begin errors++; $display("FAIL reset_out_id: got %0d expected 0", bus.out_id); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL reset_core_rst_n: got %b expected 0", core_rst_n); end
        checks++; if ({core_serial_a, core_serial_b} !== 2'b00) begin errors++; $display("FAIL reset_serial: got %b%b expected 00", core_serial_a, core_serial_b); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef TC_SCHED_TIMEOUT_EN
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
`endif
        rst = 1'b0;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    // Full job for requester o, cycle-stepped; optional out_ready stall on result stall_res.
    task automatic run_job(input int unsigned o, input int unsigned stall_res, input int unsigned stall_len);
        logic [15:0] sa, sb, ea, eb;
        logic [31:0] ew;
        logic [NUM_REQ-1:0] eg;
        bit ok;
        eg = '0; eg[o] = 1'b1;
        bus.req = eg; bus.in_valid = '1; bus.out_ready = 1'b1; core_serial_out = 1'b0;
        bus.in_a = {NUM_REQ{16'hDEAD}}; bus.in_b = {NUM_REQ{16'hBEEF}};
        tick;
        checks++; if (bus.grant !== eg) begin errors++; $display("FAIL job_grant: got %b expected %b", bus.grant, eg); end
        checks++; if ({core_rst_n, busy, bus.in_ready} !== 3'b010) begin errors++; $display("FAIL job_crst: got rst_n/busy/in_ready %b%b%b expected 010", core_rst_n, busy, bus.in_ready); end
        bus.req = '0;
        tick;
        checks++; if ({core_rst_n, bus.in_ready} !== 2'b11) begin errors++; $display("FAIL job_load_start: got rst_n/in_ready %b%b expected 11", core_rst_n, bus.in_ready); end
        for (int unsigned w = 0; w < 16; w++) begin
            ea = 16'(w + 1);
            eb = 16'h0001 << w;
            bus.in_a[16*o +: 16] = ea;
            bus.in_b[16*o +: 16] = eb;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL load_ready w%0d: got %b expected 1", w, bus.in_ready); end
            tick;
            ok = 1'b1;
            for (int unsigned b = 0; b < 16; b++) begin
                sa[b] = core_serial_a;
                sb[b] = core_serial_b;
                if (bus.in_ready !== 1'b0 || bus.grant !== eg) ok = 1'b0;
                tick;
            end
            checks++; if (sa !== ea) begin errors++; $display("FAIL serial_a w%0d: got %h expected %h", w, sa, ea); end
            checks++; if (sb !== eb) begin errors++; $display("FAIL serial_b w%0d: got %h expected %h", w, sb, eb); end
            checks++; if (!ok) begin errors++; $display("FAIL shift_ctrl w%0d: in_ready/grant got %b/%b expected 0/%b", w, bus.in_ready, bus.grant, eg); end
        end
        ok = 1'b1;
        for (int unsigned c = 0; c < 8; c++) begin
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b1) ok = 1'b0;
            tick;
        end
        checks++; if (!ok) begin errors++; $display("FAIL compute_phase: got in_ready/out_valid %b/%b expected 0/0", bus.in_ready, bus.out_valid); end
        for (int unsigned r = 0; r < 16; r++) begin
            ew = exp_word(r);
            ok = 1'b1;
            for (int unsigned b = 0; b < 32; b++) begin
                core_serial_out = ew[b];
                if (bus.out_valid !== 1'b0) ok = 1'b0;
                tick;
            end
            core_serial_out = ~ew[0];
            checks++; if (!ok) begin errors++; $display("FAIL unload_valid r%0d: got out_valid during unload, expected 0", r); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL out_valid r%0d: got %b expected 1", r, bus.out_valid); end
            checks++; if (bus.out_data !== ew) begin errors++; $display("FAIL out_data r%0d: got %h expected %h", r, bus.out_data, ew); end
            checks++; if (bus.out_id !== 3'(o)) begin errors++; $display("FAIL out_id r%0d: got %0d expected %0d", r, bus.out_id, o); end
            if (r == stall_res) begin
                bus.out_ready = 1'b0;
                ok = 1'b1;
                for (int unsigned s = 0; s < stall_len; s++) begin
                    core_serial_out = s[0];
                    tick;
                    if (bus.out_valid !== 1'b1 || bus.out_data !== ew) ok = 1'b0;
                end
                checks++; if (!ok) begin errors++; $display("FAIL stall_hold r%0d: got valid/data %b/%h expected 1/%h", r, bus.out_valid, bus.out_data, ew); end
                bus.out_ready = 1'b1;
            end
            tick;
        end
        checks++; if ({bus.grant, busy} !== {{NUM_REQ{1'b0}}, 1'b1}) begin errors++; $display("FAIL release: got grant/busy %b/%b expected 0/1", bus.grant, busy); end
        tick;
        checks++; if ({bus.grant, busy} !== '0) begin errors++; $display("FAIL job_end: got grant/busy %b/%b expected 0/0", bus.grant, busy); end
    endtask

    task automatic test_single_job;
        run_job(2, 99, 0);
    endtask

    task automatic test_round_robin;
        int unsigned gap, len;
        logic [NUM_REQ-1:0] eg;
        bus.in_valid = '1; bus.out_ready = 1'b1; core_serial_out = 1'b0;
        bus.req = '1; rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        for (int unsigned j = 0; j < 5; j++) begin
            gap = 0;
            while (busy !== 1'b1 && gap < 20) begin tick; gap++; end
            checks++; if (gap != 1) begin errors++; $display("FAIL rr_gap j%0d: got %0d idle cycles expected 1", j, gap); end
            eg = '0; eg[j % NUM_REQ] = 1'b1;
            checks++; if (bus.grant !== eg) begin errors++; $display("FAIL rr_grant j%0d: got %b expected %b", j, bus.grant, eg); end
            if (j == 4) bus.req = '0;
            len = 0;
            while (busy === 1'b1 && len < 2000) begin len++; tick; end
            checks++; if (len != BUSY_LEN) begin errors++; $display("FAIL busy_len j%0d: got %0d expected %0d", j, len, BUSY_LEN); end
        end
    endtask

    task automatic test_out_stall;
        run_job(1, 5, 50);
    endtask

    task automatic test_reset_mid_load;
        bus.req = 4'b0100; bus.in_valid = '1; bus.out_ready = 1'b1; core_serial_out = 1'b0;
        repeat (2 + 7*17 + 1 + 5) tick;
        checks++; if ({bus.in_ready, busy, bus.grant} !== {2'b01, 4'b0100}) begin errors++; $display("FAIL mid_load_state: got in_ready/busy/grant %b/%b/%b expected 0/1/0100", bus.in_ready, busy, bus.grant); end
        rst = 1'b1;
        tick;
        bus.req = '0;
        checks++; if ({bus.grant, bus.in_ready, bus.out_valid, busy, core_rst_n} !== '0) begin errors++; $display("FAIL mid_reset_ctrl: got grant/in_ready/out_valid/busy/core_rst_n %b/%b/%b/%b/%b expected all 0", bus.grant, bus.in_ready, bus.out_valid, busy, core_rst_n); end
        checks++; if ({bus.out_data, bus.out_id} !== '0) begin errors++; $display("FAIL mid_reset_data: got out_data/out_id %h/%0d expected 0/0", bus.out_data, bus.out_id); end
        checks++; if ({core_serial_a, core_serial_b} !== 2'b00) begin errors++; $display("FAIL mid_reset_serial: got %b%b expected 00", core_serial_a, core_serial_b); end
        rst = 1'b0;
        tick;
        run_job(2, 99, 0);
    endtask

`ifdef TC_SCHED_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        bus.req = 4'b0110; bus.in_valid = '1; bus.out_ready = 1'b1; core_serial_out = 1'b0;
        tick;
        checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL to_grant1: got %b expected 0010", bus.grant); end
        tick;
        for (int unsigned w = 0; w < 4; w++) begin
            tick;
            if (w == 3) bus.in_valid = '0;
            repeat (16) tick;
        end
        ok = 1'b1;
        for (int unsigned k = 0; k < 16; k++) begin
            if (timeout_err !== 1'b0 || bus.in_ready !== 1'b1) ok = 1'b0;
            tick;
        end
        checks++; if (!ok) begin errors++; $display("FAIL to_wait: early timeout_err or in_ready low, got %b/%b", timeout_err, bus.in_ready); end
        checks++; if ({timeout_err, core_rst_n, bus.out_valid} !== 3'b100) begin errors++; $display("FAIL to_abort: got err/rst_n/out_valid %b%b%b expected 100", timeout_err, core_rst_n, bus.out_valid); end
        checks++; if (bus.out_id !== 3'd1) begin errors++; $display("FAIL to_out_id: got %0d expected 1", bus.out_id); end
        tick;
        checks++; if ({bus.grant, timeout_err} !== 5'b0) begin errors++; $display("FAIL to_release: got grant/err %b/%b expected 0/0", bus.grant, timeout_err); end
        tick; tick;
        checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL to_grant2: got %b expected 0100", bus.grant); end
        bus.req = '0; rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_single_job;
        test_round_robin;
        test_out_stall;
        test_reset_mid_load;
`ifdef TC_SCHED_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
